// File: rtl/bigint_pkg.sv
// Shared constants and types for the big-number datapath memory side.
package bigint_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ADDR_WIDTH       = 8;
  localparam int WORDS_PER_NUMBER = 64;

  // Which requester issued a read; it decides which valid output fires.
  typedef enum logic {
    REQ_ADDER = 1'b0,
    REQ_HOST  = 1'b1
  } req_tag_e;

endpackage

// File: rtl/word_bank_responder_bank_ram.sv
// 1R1W block RAM with READ_LATENCY registered output stages.
// Read-first: a read and write to the same address at the same edge
// returns the old word; the parent handles forwarding of new data.
module bank_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  output logic [DATA_WIDTH-1:0] rd_data_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0] stage_q [READ_LATENCY];

  // Storage array; no reset so contents survive a reset pulse.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_q[wr_addr_in] <= wr_data_in;
    end
  end

  // Stage 0 samples the array before this edge's write lands; later stages just delay.
  always_comb begin
    stage_d[0] = mem_q[rd_addr_in];
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Output pipeline registers, cleared on reset so the read data reads zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign rd_data_out = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/word_bank_responder.sv
// Word bank responder: mirrored X/Y RAM copies shared between the adder
// and a host load/readback port, with adder priority, same-edge write
// forwarding and a tagged fixed-latency response pipeline.
module word_bank_responder #(
  parameter int DATA_WIDTH   = bigint_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = bigint_pkg::ADDR_WIDTH,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  request_valid_in,
  input  logic [ADDR_WIDTH-1:0] x_request_in,
  input  logic [ADDR_WIDTH-1:0] y_request_in,
  output logic                  received_valid_out,
  output logic [DATA_WIDTH-1:0] x_data_out,
  output logic [DATA_WIDTH-1:0] y_data_out,
  input  logic                  valid_write_in,
  input  logic [ADDR_WIDTH-1:0] write_data_pointer_in,
  input  logic [DATA_WIDTH-1:0] data_to_store_in,
  input  logic                  host_wr_valid_in,
  input  logic                  host_rd_valid_in,
  input  logic [ADDR_WIDTH-1:0] host_addr_in,
  input  logic [DATA_WIDTH-1:0] host_data_in,
  output logic                  host_wr_ready_out,
  output logic                  host_rd_ready_out,
  output logic                  host_rd_valid_out,
  output logic [DATA_WIDTH-1:0] host_rd_data_out
);

  import bigint_pkg::*;

  logic                  host_wr_accept;
  logic                  host_rd_accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] x_rd_addr;
  logic                  rd_issue;
  req_tag_e              rd_tag;
  logic                  x_hit;
  logic                  y_hit;

  logic                  vld_d   [READ_LATENCY];
  logic                  vld_q   [READ_LATENCY];
  req_tag_e              tag_d   [READ_LATENCY];
  req_tag_e              tag_q   [READ_LATENCY];
  logic                  x_hit_d [READ_LATENCY];
  logic                  x_hit_q [READ_LATENCY];
  logic                  y_hit_d [READ_LATENCY];
  logic                  y_hit_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] fwd_d   [READ_LATENCY];
  logic [DATA_WIDTH-1:0] fwd_q   [READ_LATENCY];

  logic [DATA_WIDTH-1:0] x_ram_data;
  logic [DATA_WIDTH-1:0] y_ram_data;
  logic [DATA_WIDTH-1:0] x_rsp_data;
  logic [DATA_WIDTH-1:0] y_rsp_data;

  assign host_wr_ready_out = !valid_write_in;
  assign host_rd_ready_out = !request_valid_in;

  // Arbitration of the shared write port and X read port; adder always wins.
  always_comb begin
    host_wr_accept = host_wr_valid_in && host_wr_ready_out;
    host_rd_accept = host_rd_valid_in && host_rd_ready_out;
    // A write sampled during reset is dropped.
    wr_en          = !rst_in && (valid_write_in || host_wr_accept);
    wr_addr        = valid_write_in ? write_data_pointer_in : host_addr_in;
    wr_data        = valid_write_in ? data_to_store_in : host_data_in;
    x_rd_addr      = request_valid_in ? x_request_in : host_addr_in;
    rd_issue       = request_valid_in || host_rd_accept;
    rd_tag         = request_valid_in ? REQ_ADDER : REQ_HOST;
    x_hit          = wr_en && (wr_addr == x_rd_addr);
    y_hit          = wr_en && (wr_addr == y_request_in);
  end

  // Shift the tag, valid and forwarding info alongside the RAM output stages.
  always_comb begin
    vld_d[0]   = rd_issue;
    tag_d[0]   = rd_tag;
    x_hit_d[0] = x_hit;
    y_hit_d[0] = y_hit;
    fwd_d[0]   = wr_data;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      tag_d[i]   = tag_q[i-1];
      x_hit_d[i] = x_hit_q[i-1];
      y_hit_d[i] = y_hit_q[i-1];
      fwd_d[i]   = fwd_q[i-1];
    end
  end

  // Response pipeline registers; reset drops every in-flight read.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i]   <= 1'b0;
        tag_q[i]   <= REQ_ADDER;
        x_hit_q[i] <= 1'b0;
        y_hit_q[i] <= 1'b0;
        fwd_q[i]   <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      x_hit_q <= x_hit_d;
      y_hit_q <= y_hit_d;
      fwd_q   <= fwd_d;
    end
  end

  bank_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_x_ram (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en_in   (wr_en),
    .wr_addr_in (wr_addr),
    .wr_data_in (wr_data),
    .rd_addr_in (x_rd_addr),
    .rd_data_out(x_ram_data)
  );

  bank_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_y_ram (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en_in   (wr_en),
    .wr_addr_in (wr_addr),
    .wr_data_in (wr_data),
    .rd_addr_in (y_request_in),
    .rd_data_out(y_ram_data)
  );

  // Forwarded write data replaces the read-first RAM word on an address hit.
  always_comb begin
    x_rsp_data = x_hit_q[READ_LATENCY-1] ? fwd_q[READ_LATENCY-1] : x_ram_data;
    y_rsp_data = y_hit_q[READ_LATENCY-1] ? fwd_q[READ_LATENCY-1] : y_ram_data;
  end

  assign received_valid_out = vld_q[READ_LATENCY-1] && (tag_q[READ_LATENCY-1] == REQ_ADDER);
  assign host_rd_valid_out  = vld_q[READ_LATENCY-1] && (tag_q[READ_LATENCY-1] == REQ_HOST);
  assign x_data_out         = x_rsp_data;
  assign y_data_out         = y_rsp_data;
  assign host_rd_data_out   = x_rsp_data;

endmodule

// File: tb/tb_word_bank_responder.sv
`timescale 1ns/1ps
// Bench for word_bank_responder: directed scenarios plus a randomized run
// against a word-array model with a queue of pending responses.
module tb_word_bank_responder;
  import bigint_pkg::*;

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int L   = 2;
  localparam int WPN = WORDS_PER_NUMBER;

  logic          clk = 1'b0;
  logic          rst;
  logic          request_valid_in;
  logic [AW-1:0] x_request_in, y_request_in;
  logic          received_valid_out;
  logic [DW-1:0] x_data_out, y_data_out;
  logic          valid_write_in;
  logic [AW-1:0] write_data_pointer_in;
  logic [DW-1:0] data_to_store_in;
  logic          host_wr_valid_in, host_rd_valid_in;
  logic [AW-1:0] host_addr_in;
  logic [DW-1:0] host_data_in;
  logic          host_wr_ready_out, host_rd_ready_out;
  logic          host_rd_valid_out;
  logic [DW-1:0] host_rd_data_out;

  always #5 clk = ~clk;

  word_bank_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
    .clk_in               (clk),
    .rst_in               (rst),
    .request_valid_in     (request_valid_in),
    .x_request_in         (x_request_in),
    .y_request_in         (y_request_in),
    .received_valid_out   (received_valid_out),
    .x_data_out           (x_data_out),
    .y_data_out           (y_data_out),
    .valid_write_in       (valid_write_in),
    .write_data_pointer_in(write_data_pointer_in),
    .data_to_store_in     (data_to_store_in),
    .host_wr_valid_in     (host_wr_valid_in),
    .host_rd_valid_in     (host_rd_valid_in),
    .host_addr_in         (host_addr_in),
    .host_data_in         (host_data_in),
    .host_wr_ready_out    (host_wr_ready_out),
    .host_rd_ready_out    (host_rd_ready_out),
    .host_rd_valid_out    (host_rd_valid_out),
    .host_rd_data_out     (host_rd_data_out)
  );

  typedef struct packed {
    logic          valid;
    logic          host;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } resp_t;

  logic [DW-1:0] mem_m [256];
  resp_t         pend_q [$];
  resp_t         exp_r;
  int            total = 0;
  int            bad   = 0;

  task automatic clear_inputs();
    request_valid_in      = 1'b0;
    x_request_in          = '0;
    y_request_in          = '0;
    valid_write_in        = 1'b0;
    write_data_pointer_in = '0;
    data_to_store_in      = '0;
    host_wr_valid_in      = 1'b0;
    host_rd_valid_in      = 1'b0;
    host_addr_in          = '0;
    host_data_in          = '0;
  endtask

  // Model the edge about to happen, advance one clock, and expose the
  // response expected to be visible now (issued L-1 edges earlier).
  task automatic tick();
    resp_t e;
    e = '0;
    if (rst) begin
      pend_q.delete();
    end else begin
      if (valid_write_in)        mem_m[write_data_pointer_in] = data_to_store_in;
      else if (host_wr_valid_in) mem_m[host_addr_in] = host_data_in;
      e.valid = request_valid_in || host_rd_valid_in;
      e.host  = !request_valid_in;
      e.x     = request_valid_in ? mem_m[x_request_in] : mem_m[host_addr_in];
      e.y     = mem_m[y_request_in];
    end
    pend_q.push_back(e);
    if (pend_q.size() > L) void'(pend_q.pop_front());
    @(posedge clk);
    #1;
    exp_r = (pend_q.size() >= L) ? pend_q[pend_q.size()-L] : '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++; if (received_valid_out !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", received_valid_out); end
    total++; if (host_rd_valid_out !== 1'b0) begin bad++; $display("FAIL rst_hv got=%b want=0", host_rd_valid_out); end
    total++; if (x_data_out !== '0) begin bad++; $display("FAIL rst_x got=%h want=0", x_data_out); end
    total++; if (y_data_out !== '0) begin bad++; $display("FAIL rst_y got=%h want=0", y_data_out); end
    total++; if (host_rd_data_out !== '0) begin bad++; $display("FAIL rst_hd got=%h want=0", host_rd_data_out); end
    total++; if (host_wr_ready_out !== 1'b1 || host_rd_ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b%b want=11", host_wr_ready_out, host_rd_ready_out); end
    valid_write_in   = 1'b1;
    request_valid_in = 1'b1;
    #1;
    total++; if (host_wr_ready_out !== 1'b0 || host_rd_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready_busy got=%b%b want=00", host_wr_ready_out, host_rd_ready_out); end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_host_write_read();
    clear_inputs();
    host_wr_valid_in = 1'b1; host_addr_in = 8'd5; host_data_in = 32'hDEADBEEF;
    #1;
    total++; if (host_wr_ready_out !== 1'b1) begin bad++; $display("FAIL hw_ready got=%b want=1", host_wr_ready_out); end
    tick();
    clear_inputs();
    request_valid_in = 1'b1; x_request_in = 8'd5; y_request_in = 8'd5;
    tick();
    clear_inputs();
    for (int i = 0; i < L-1; i++) begin
      total++; if (received_valid_out !== 1'b0) begin bad++; $display("FAIL hwr_early got=%b want=0", received_valid_out); end
      tick();
    end
    total++; if (received_valid_out !== 1'b1) begin bad++; $display("FAIL hwr_valid got=%b want=1", received_valid_out); end
    total++; if (x_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL hwr_x got=%h want=deadbeef", x_data_out); end
    total++; if (y_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL hwr_y got=%h want=deadbeef", y_data_out); end
    total++; if (host_rd_valid_out !== 1'b0) begin bad++; $display("FAIL hwr_hv got=%b want=0", host_rd_valid_out); end
    tick();
    total++; if (received_valid_out !== 1'b0) begin bad++; $display("FAIL hwr_pulse got=%b want=0", received_valid_out); end
  endtask

  task automatic test_back_to_back();
    int  k;
    logic want_v;
    logic [DW-1:0] want_d;
    clear_inputs();
    for (int i = 0; i < WPN; i++) begin
      host_wr_valid_in = 1'b1; host_addr_in = AW'(i); host_data_in = DW'(i);
      tick();
    end
    clear_inputs();
    for (int c = 0; c < WPN + L; c++) begin
      if (c < WPN) begin
        request_valid_in = 1'b1;
        x_request_in = AW'(WPN-1-c);
        y_request_in = AW'(WPN-1-c);
      end else begin
        clear_inputs();
      end
      tick();
      k      = c - (L-1);
      want_v = (k >= 0) && (k < WPN);
      want_d = DW'(WPN-1-k);
      total++; if (received_valid_out !== want_v) begin bad++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, received_valid_out, want_v); end
      if (want_v) begin
        total++; if (x_data_out !== want_d || y_data_out !== want_d) begin bad++; $display("FAIL b2b_data c=%0d got=%h/%h want=%h", c, x_data_out, y_data_out, want_d); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_bypass();
    clear_inputs();
    host_wr_valid_in = 1'b1; host_addr_in = 8'd10; host_data_in = 32'h5555_5555;
    tick();
    clear_inputs();
    valid_write_in = 1'b1; write_data_pointer_in = 8'd10; data_to_store_in = 32'h0000_1234;
    request_valid_in = 1'b1; x_request_in = 8'd10; y_request_in = 8'd10;
    tick();
    clear_inputs();
    repeat (L-1) tick();
    total++; if (received_valid_out !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b want=1", received_valid_out); end
    total++; if (x_data_out !== 32'h1234 || y_data_out !== 32'h1234) begin bad++; $display("FAIL byp_data got=%h/%h want=1234", x_data_out, y_data_out); end
    // host read forwarded from an adder write at the same edge
    valid_write_in = 1'b1; write_data_pointer_in = 8'd20; data_to_store_in = 32'h0000_7777;
    host_rd_valid_in = 1'b1; host_addr_in = 8'd20;
    tick();
    clear_inputs();
    repeat (L-1) tick();
    total++; if (host_rd_valid_out !== 1'b1) begin bad++; $display("FAIL byp_hv got=%b want=1", host_rd_valid_out); end
    total++; if (host_rd_data_out !== 32'h7777) begin bad++; $display("FAIL byp_hd got=%h want=7777", host_rd_data_out); end
  endtask

  task automatic test_host_starve();
    clear_inputs();
    request_valid_in = 1'b1; host_rd_valid_in = 1'b1; host_addr_in = 8'd40;
    for (int i = 0; i < 6; i++) begin
      x_request_in = AW'($urandom_range(0, WPN-1));
      y_request_in = AW'($urandom_range(0, WPN-1));
      #1;
      total++; if (host_rd_ready_out !== 1'b0) begin bad++; $display("FAIL starve_ready i=%0d got=%b want=0", i, host_rd_ready_out); end
      tick();
      total++; if (host_rd_valid_out !== 1'b0) begin bad++; $display("FAIL starve_hv i=%0d got=%b want=0", i, host_rd_valid_out); end
    end
    request_valid_in = 1'b0;
    #1;
    total++; if (host_rd_ready_out !== 1'b1) begin bad++; $display("FAIL starve_grant got=%b want=1", host_rd_ready_out); end
    tick();
    clear_inputs();
    for (int i = 0; i < L-1; i++) begin
      total++; if (host_rd_valid_out !== 1'b0) begin bad++; $display("FAIL starve_early got=%b want=0", host_rd_valid_out); end
      tick();
    end
    total++; if (host_rd_valid_out !== 1'b1) begin bad++; $display("FAIL starve_hv_fire got=%b want=1", host_rd_valid_out); end
    total++; if (host_rd_data_out !== 32'd40) begin bad++; $display("FAIL starve_hd got=%h want=28", host_rd_data_out); end
    total++; if (received_valid_out !== 1'b0) begin bad++; $display("FAIL starve_rv got=%b want=0", received_valid_out); end
  endtask

  task automatic test_write_collision();
    clear_inputs();
    valid_write_in = 1'b1; write_data_pointer_in = 8'd3; data_to_store_in = 32'hA;
    host_wr_valid_in = 1'b1; host_addr_in = 8'd3; host_data_in = 32'hB;
    request_valid_in = 1'b1; x_request_in = 8'd3; y_request_in = 8'd3;
    #1;
    total++; if (host_wr_ready_out !== 1'b0) begin bad++; $display("FAIL col_ready got=%b want=0", host_wr_ready_out); end
    tick();
    valid_write_in = 1'b0; request_valid_in = 1'b0;
    #1;
    total++; if (host_wr_ready_out !== 1'b1) begin bad++; $display("FAIL col_ready_hold got=%b want=1", host_wr_ready_out); end
    tick();
    clear_inputs();
    for (int i = 1; i < L-1; i++) tick();
    total++; if (received_valid_out !== 1'b1) begin bad++; $display("FAIL col_valid got=%b want=1", received_valid_out); end
    total++; if (x_data_out !== 32'hA || y_data_out !== 32'hA) begin bad++; $display("FAIL col_adder_wins got=%h/%h want=a", x_data_out, y_data_out); end
    request_valid_in = 1'b1; x_request_in = 8'd3; y_request_in = 8'd3;
    tick();
    clear_inputs();
    repeat (L-1) tick();
    total++; if (x_data_out !== 32'hB || y_data_out !== 32'hB) begin bad++; $display("FAIL col_host_commit got=%h/%h want=b", x_data_out, y_data_out); end
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      request_valid_in = 1'b1; x_request_in = AW'(i); y_request_in = AW'(i);
      tick();
    end
    clear_inputs();
    rst = 1'b1;
    valid_write_in = 1'b1; write_data_pointer_in = 8'd7; data_to_store_in = 32'hBAD0_BAD0;
    tick();
    clear_inputs();
    rst = 1'b0;
    total++; if (received_valid_out !== 1'b0 || host_rd_valid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b%b want=00", received_valid_out, host_rd_valid_out); end
    total++; if (x_data_out !== '0 || y_data_out !== '0 || host_rd_data_out !== '0) begin bad++; $display("FAIL mid_rst_data got=%h/%h/%h want=0", x_data_out, y_data_out, host_rd_data_out); end
    for (int i = 0; i < L+2; i++) begin
      tick();
      total++; if (received_valid_out !== 1'b0 || host_rd_valid_out !== 1'b0) begin bad++; $display("FAIL mid_ghost i=%0d got=%b%b want=00", i, received_valid_out, host_rd_valid_out); end
    end
    request_valid_in = 1'b1; x_request_in = 8'd7; y_request_in = 8'd3;
    tick();
    clear_inputs();
    repeat (L-1) tick();
    total++; if (received_valid_out !== 1'b1) begin bad++; $display("FAIL mid_after_valid got=%b want=1", received_valid_out); end
    total++; if (x_data_out !== 32'd7 || y_data_out !== 32'hB) begin bad++; $display("FAIL mid_retained got=%h/%h want=7/b", x_data_out, y_data_out); end
  endtask

  task automatic test_random();
    logic want_rv, want_hv;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      rst                   = ($urandom_range(0, 39) == 0);
      request_valid_in      = $urandom_range(0, 1) == 1;
      x_request_in          = AW'($urandom_range(0, 15));
      y_request_in          = AW'($urandom_range(0, 15));
      valid_write_in        = $urandom_range(0, 2) == 0;
      write_data_pointer_in = AW'($urandom_range(0, 15));
      data_to_store_in      = $urandom;
      host_wr_valid_in      = $urandom_range(0, 2) == 0;
      host_rd_valid_in      = $urandom_range(0, 2) == 0;
      host_addr_in          = AW'($urandom_range(0, 15));
      host_data_in          = $urandom;
      #1;
      total++; if (host_wr_ready_out !== !valid_write_in || host_rd_ready_out !== !request_valid_in) begin bad++; $display("FAIL rnd_ready c=%0d got=%b%b want=%b%b", c, host_wr_ready_out, host_rd_ready_out, !valid_write_in, !request_valid_in); end
      tick();
      want_rv = exp_r.valid && !exp_r.host;
      want_hv = exp_r.valid && exp_r.host;
      total++; if (received_valid_out !== want_rv || host_rd_valid_out !== want_hv) begin bad++; $display("FAIL rnd_valid c=%0d got=%b%b want=%b%b", c, received_valid_out, host_rd_valid_out, want_rv, want_hv); end
      if (want_rv) begin
        total++; if (x_data_out !== exp_r.x || y_data_out !== exp_r.y) begin bad++; $display("FAIL rnd_data c=%0d got=%h/%h want=%h/%h", c, x_data_out, y_data_out, exp_r.x, exp_r.y); end
      end
      if (want_hv) begin
        total++; if (host_rd_data_out !== exp_r.x) begin bad++; $display("FAIL rnd_hdata c=%0d got=%h want=%h", c, host_rd_data_out, exp_r.x); end
      end
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_host_write_read();
    test_back_to_back();
    test_bypass();
    test_host_starve();
    test_write_collision();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_bank_responder.md
# word_bank_responder

Memory-side responder for the big-number datapath: a 256-word × 32-bit bank holding 2048-bit operands and results as 64-word blocks. It serves paired x/y read requests at fixed latency and absorbs 32-bit result writes from the ripple-carry big-number adder. A host load/readback port shares the bank when the adder leaves a port idle. It sits between the adder and the top-level, which uses the host port for operand loading and result readback.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, word address width; depth is 2**ADDR_WIDTH
- READ_LATENCY, 2, cycles from sampled request to response valid; legal values are 1–4
- clk_in  input  1  single clock for the block
- rst_in  input  1  reset, synchronous and active-high
- request_valid_in  input  1  adder read request, one per cycle when high
- x_request_in / y_request_in  input  ADDR_WIDTH  read addresses
- received_valid_out  output  1  response valid
- x_data_out / y_data_out  output  DATA_WIDTH  read data
- valid_write_in  input  1  adder write strobe
- write_data_pointer_in  input  ADDR_WIDTH  write address
- data_to_store_in  input  DATA_WIDTH  write data
- host_wr_valid_in, host_rd_valid_in  input  1  host write and read strobes
- host_addr_in  input  ADDR_WIDTH  host address, shared by host read and write
- host_data_in  input  DATA_WIDTH  host write data
- host_wr_ready_out, host_rd_ready_out  output  1  grant signals, combinational
- host_rd_valid_out  output  1  host read response valid
- host_rd_data_out  output  DATA_WIDTH  host read data

## Operation
- Storage is two mirrored 1R1W copies, X and Y. Every accepted write goes to both copies at the same address.
- Write port arbitration:
  - Adder has priority.
  - host_wr_ready_out = !valid_write_in.
  - A host write is accepted when host_wr_valid_in && host_wr_ready_out.
- X read port arbitration:
  - Adder has priority.
  - host_rd_ready_out = !request_valid_in.
  - The host may starve while the adder streams requests; this is intended behaviour.
- Responses come back in order and fully pipelined. A new request may be issued every cycle, with no backpressure.
- Each response tag records whether the read belongs to the adder or the host. The tag selects which valid output fires: received_valid_out or host_rd_valid_out, never both for the same request.
- Same-cycle write bypass:
  - If a write is accepted at the same edge as a read sampled to the same address, the read returns the new write data.
  - The check is made per port: X against x_request_in or host_addr_in, Y against y_request_in.
- Writes accepted at earlier edges are already committed, so no further forwarding is needed.
- Addresses are ADDR_WIDTH wide and wrap naturally. There is no out-of-range case.

## Timing
- A request sampled at edge k produces its valid output high in exactly one cycle, edge k+READ_LATENCY, with data stable in that same cycle.
- Valid outputs are single-cycle pulses per request. Back-to-back requests give a continuous valid stream.
- A write accepted at edge w is visible to every read sampled at edge w or later.
- Reset values:
  - received_valid_out = 0, host_rd_valid_out = 0.
  - x_data_out, y_data_out, host_rd_data_out = 0.
  - The readies follow their combinational equations.
- Reset mid-operation:
  - All in-flight reads are dropped; no valid fires after reset.
  - A write sampled in the reset cycle is discarded.
  - Memory contents are retained, not cleared.
- Simultaneous adder and host write: the adder write commits. The host write is not accepted and must be held by the host.

## Structure
- Package bigint_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, WORDS_PER_NUMBER = 64.
  - Requester tag typedef: enum {REQ_ADDER, REQ_HOST}.
- Sub-module bank_ram: 1R1W block RAM with READ_LATENCY registered output stages, read-first behaviour. It is instantiated twice, once as the X copy and once as the Y copy.
- The top level holds the arbitration, the bypass comparators, and the tag/valid shift register of depth READ_LATENCY.

## Test plan
- Host writes 0xDEADBEEF to address 5, then the adder reads x=5, y=5 → one cycle, READ_LATENCY edges later: received_valid_out=1, x_data_out=y_data_out=0xDEADBEEF.
- Host preloads addresses 0–63 with value = index. The adder issues 64 back-to-back requests x=63..0, y=63..0 → 64 contiguous valid cycles with descending data and correct ordering.
- Adder writes 0x1234 to address 10 and requests x=10 at the same edge → response is 0x1234, not the stale value.
- request_valid_in held high with host_rd_valid_in high → host_rd_ready_out=0 throughout. Deassert the request → host read is granted and host_rd_valid_out fires READ_LATENCY later.
- Adder and host write at the same edge to address 3 (0xA vs 0xB) → host_wr_ready_out=0 and address 3 reads 0xA. Host holds its write and commits it next cycle → address 3 reads 0xB.
- Issue 3 requests, then assert rst_in for one cycle → no valid pulses after reset, outputs read 0, and a subsequent read returns the pre-reset memory contents.
